// File: rtl/fifo_burst_drain.sv
// fifo_burst_drain: drains an upstream FIFO onto a valid/ready stream in
// bursts framed by last_o. A burst of BURST_LEN beats starts once that many
// entries are buffered. A shorter burst of whatever is buffered starts after
// TIMEOUT idle cycles with residual data (TIMEOUT=0 disables partial bursts).
module fifo_burst_drain #(
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int BURST_LEN   = 4,
    parameter int TIMEOUT     = 16,
    parameter int USAGE_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) + 1 : 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic [DATA_WIDTH-1:0]  fifo_data_i,
    input  logic                   fifo_empty_i,
    input  logic [USAGE_WIDTH-1:0] fifo_usage_i,
    output logic                   fifo_pop_o,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   last_o,
    output logic                   busy_o,
    output logic                   partial_o
);

    // Timer must hold values up to TIMEOUT-1; keep at least one bit when disabled.
    localparam int TIMER_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [USAGE_WIDTH-1:0] FULL_LEN   = USAGE_WIDTH'(BURST_LEN);

    if (BURST_LEN < 1 || BURST_LEN > FIFO_DEPTH) begin : g_bad_burst_len
        $error("fifo_burst_drain: BURST_LEN must lie in 1..FIFO_DEPTH");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [USAGE_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [USAGE_WIDTH-1:0] len_q, len_d;
    logic                   partial_q, partial_d;
    logic                   handshake;

    // Stream outputs: combinational head-of-FIFO pass-through, gated off while
    // the FIFO is (illegally) empty and in the cycle a flush or reset lands.
    always_comb begin
        busy_o     = (state_q == ST_BURST);
        partial_o  = partial_q;
        data_o     = fifo_data_i;
        valid_o    = busy_o && !fifo_empty_i && !flush_i && !rst_i;
        fifo_pop_o = valid_o && ready_i;
        handshake  = fifo_pop_o;
        last_o     = valid_o && (beat_cnt_q == len_q - 1'b1);
    end

    // Next-state: burst start decisions in IDLE, beat counting in BURST.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        partial_d  = partial_q;
        case (state_q)
            ST_IDLE: begin
                if (fifo_usage_i >= FULL_LEN) begin
                    state_d   = ST_BURST;
                    len_d     = FULL_LEN;
                    partial_d = 1'b0;
                    timer_d   = '0;
                end else if ((TIMEOUT != 0) && (fifo_usage_i != '0) && (timer_q == TIMER_LAST)) begin
                    // Residual data waited long enough: ship what is there.
                    state_d   = ST_BURST;
                    len_d     = fifo_usage_i;
                    partial_d = 1'b1;
                    timer_d   = '0;
                end else if (fifo_usage_i != '0) begin
                    // Saturate rather than wrap when partial bursts are disabled.
                    if (timer_q != '1) begin
                        timer_d = timer_q + 1'b1;
                    end
                end else begin
                    timer_d = '0;
                end
            end
            ST_BURST: begin
                if (handshake) begin
                    if (last_o) begin
                        beat_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A flush abandons whatever burst is running; the FIFO is emptied too.
        if (flush_i) begin
            state_d    = ST_IDLE;
            timer_d    = '0;
            beat_cnt_d = '0;
            len_d      = '0;
            partial_d  = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            beat_cnt_q <= '0;
            len_q      <= '0;
            partial_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            partial_q  <= partial_d;
        end
    end

endmodule
